code_reader: RTL
================

# code_reader

Read-side companion to the `code` dual 64-bit register block. On request it snapshots either `Output0` or `Output1` and serializes the snapshot as a framed byte stream over a valid/ready handshake. It sits between `code` and any byte-wide consumer, such as a UART TX or debug FIFO. The snapshot decouples the frame contents from register updates made while the frame is in flight.

## Interface
Parameters:
- `WIDTH`, default 64: width of `Output0`/`Output1`; must be a multiple of 8. `NBYTES = WIDTH/8`.

Ports:
- `Clk`  in  1  single clock; all logic is rising-edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Req`  in  1  read request, sampled each rising edge.
- `ReqSlt`  in  1  source select sampled with `Req`: 0 selects `Output0`, 1 selects `Output1`.
- `Output0`  in  WIDTH  register 0 value from `code`.
- `Output1`  in  WIDTH  register 1 value from `code`.
- `Data`  out  8  current stream byte.
- `Valid`  out  1  `Data` is valid.
- `Ready`  in  1  consumer accepts `Data` when `Valid & Ready`.
- `Last`  out  1  current byte is the final byte of the frame.
- `Busy`  out  1  a frame is in progress.
- `Done`  out  1  one-cycle pulse after the final byte is accepted.
- `Drop`  out  1  one-cycle pulse when a `Req` is ignored because the block is busy.
- `FrameCnt`  out  8  count of completed frames; wraps 255 -> 0.

## Operation
- States: IDLE, HDR, DATA.
- IDLE:
  - On `Req=1`: latch `snap <= ReqSlt ? Output1 : Output0`, latch `sel <= ReqSlt`, clear byte index `idx`, go to HDR.
- HDR:
  - `Valid=1`, `Data = 8'hA0 | sel`.
  - On handshake, go to DATA with `idx=0`.
- DATA:
  - `Valid=1`, `Data = snap[8*idx +: 8]`; byte order is LS byte first.
  - `Last = (idx == NBYTES-1)`.
  - On handshake with `Last=1`: go to IDLE, pulse `Done`, increment `FrameCnt`.
  - On handshake otherwise: increment `idx`.
- Frame length is `NBYTES+1` bytes (9 for WIDTH=64).
- `Busy = (state != IDLE)`.
- `Drop` pulses when `Req=1` in HDR or DATA. The request is discarded, not queued.
- Register changes on `Output0`/`Output1` during a frame do not affect the frame; only `snap` is sent.
- `Data`, `Last` and `sel` are held stable while `Valid & !Ready`.
- Handshake rules:
  - `Valid` never deasserts before its handshake within a frame.
  - `Valid` does not depend combinationally on `Ready`.

## Timing
- Reset values, which are also the state one edge after `Reset=1`:
  - `Valid`, `Last`, `Busy`, `Done`, `Drop` = 0.
  - `Data`, `FrameCnt`, `snap`, `idx` = 0.
  - State = IDLE.
- Reset has priority over every other event. Reset during HDR or DATA aborts the frame: no `Done`, `FrameCnt` cleared, stream idle on the next cycle.
- Request latency: `Req` sampled at edge N gives `Busy=1`, `Valid=1` and the header on `Data` during cycle N+1.
- Each byte advances on the edge where `Valid & Ready`. With `Ready` held at 1, a frame occupies `NBYTES+1` consecutive cycles.
- Frame completion, when the final handshake occurs at edge M:
  - During cycle M+1: `Done=1`, `Busy=0`, `Valid=0`, `FrameCnt` already incremented.
- Back-to-back: a `Req` sampled at edge M+1 (the `Done` cycle, IDLE) is accepted, giving a one-cycle gap between frames.
- A `Req` sampled at edge M itself, with the block still in DATA, is dropped and pulses `Drop` during cycle M+1.
- `Done` and `Drop` are registered outputs.

## Test plan
- **Basic read:** reset, then `Output0=64'h0123456789ABCDEF`, `Req=1`, `ReqSlt=0` for one cycle, `Ready=1`.
  - Bytes A0, EF, CD, AB, 89, 67, 45, 23, 01 on 9 consecutive cycles.
  - `Last` high only on the 01 byte; `Done` pulses the cycle after; `FrameCnt=1`.
- **Select and snapshot:** `Output1=64'h5`, `Req=1`, `ReqSlt=1`; then change `Output1` to 64'hFF mid-frame.
  - Stream is A1, 05, then seven 00 bytes. The 64'hFF value never appears.
- **Backpressure:** `Ready` toggles 1,0,0,1,...
  - `Data`/`Last` hold while `Ready=0`.
  - Exactly 9 accepted bytes with values identical to the Basic read frame.
  - `Done` appears exactly once.
- **Busy request:** `Req=1` during the 3rd data byte.
  - `Drop` pulses one cycle later; the frame is unchanged.
  - A `Req` in the `Done` cycle starts a new header on the next cycle.
- **Reset mid-frame:** `Reset=1` for one cycle at the 4th byte.
  - Next cycle: `Valid=0`, `Busy=0`, `FrameCnt=0`, no `Done`.
  - A following `Req` produces a full 9-byte frame.
- **Counter wrap:** run 256 frames.
  - `FrameCnt` reads 255 after the 255th frame and 0 after the 256th.

Source files
------------

// File: rtl/code_reader.sv
// Snapshot-and-serialize reader for the dual 64-bit register block.
// Emits a header byte (A0|sel) followed by the snapshot, LS byte first, over valid/ready.
module code_reader #(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req,
    input  logic             ReqSlt,
    input  logic [WIDTH-1:0] Output0,
    input  logic [WIDTH-1:0] Output1,
    output logic [7:0]       Data,
    output logic             Valid,
    input  logic             Ready,
    output logic             Last,
    output logic             Busy,
    output logic             Done,
    output logic             Drop,
    output logic [7:0]       FrameCnt,
    output logic [1:0]       fsm_state
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    // Handshake: a byte transfers on any rising edge where Valid & Ready.
    // Valid is a function of state only, never of Ready, and once raised it
    // stays high with Data/Last frozen until that transfer happens.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] snap;
    logic [WIDTH-1:0] shifted;
    logic             sel;
    logic [IDX_W-1:0] idx;
    logic             is_last;

    assign shifted   = snap >> {idx, 3'b000};
    assign is_last   = (idx == LAST_IDX);
    assign Busy      = (state != IDLE);
    assign fsm_state = state;

    always_comb begin
        next_state = state;
        Valid      = 1'b0;
        Last       = 1'b0;
        Data       = 8'h00;
        case (state)
            IDLE: begin
                if (Req) next_state = HDR;
            end
            HDR: begin
                Valid = 1'b1;
                Data  = 8'hA0 | {7'd0, sel};
                if (Ready) next_state = DATA;
            end
            DATA: begin
                Valid = 1'b1;
                Data  = shifted[7:0];
                Last  = is_last;
                if (Ready && is_last) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            snap     <= '0;
            sel      <= 1'b0;
            idx      <= '0;
            Done     <= 1'b0;
            Drop     <= 1'b0;
            FrameCnt <= 8'd0;
        end else begin
            state <= next_state;
            Done  <= 1'b0;
            Drop  <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req) begin
                        snap <= ReqSlt ? Output1 : Output0;
                        sel  <= ReqSlt;
                        idx  <= '0;
                    end
                end
                HDR: begin
                    if (Req) Drop <= 1'b1;
                    if (Ready) idx <= '0;
                end
                DATA: begin
                    // Requests while busy are discarded, only flagged.
                    if (Req) Drop <= 1'b1;
                    if (Ready) begin
                        if (is_last) begin
                            Done     <= 1'b1;
                            FrameCnt <= FrameCnt + 8'd1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
